// File: rtl/imem_loader.sv
// Bootloader front end: parses SYNC/LEN/DATA/CHK frames from a UART byte
// stream and drives the instruction memory programming port, holding the
// core while a frame is being loaded.
module imem_loader #(
   parameter int unsigned ADDR_W      = 14,
   parameter int unsigned BASE_ADDR   = 0,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [ADDR_W-1:0] write_addr,
   output logic [31:0]       write_data,
   output logic              w_en,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
   } state_t;

   // Capacity in words, widened so the LEN comparison cannot overflow.
   localparam logic [32:0]       DEPTH = (33'd1 << (ADDR_W - 2)) - 33'(BASE_ADDR / 4);
   localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       word_cnt_q, word_cnt_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [23:0]       asm_q, asm_d;
   logic [7:0]        chk_q, chk_d;
   logic [31:0]       tmo_q, tmo_d;
   logic [ADDR_W-1:0] write_addr_q, write_addr_d;
   logic [31:0]       write_data_q, write_data_d;
   logic              w_en_q, w_en_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              load_done_q, load_done_d;
   logic              load_err_q, load_err_d;

   logic              sync_hit;
   logic              tmo_hit;
   logic [15:0]       len_full;

   assign sync_hit = rx_valid && (rx_data == SYNC_BYTE);
   assign tmo_hit  = (TIMEOUT_CYC != 0) && !rx_valid && (tmo_q == TIMEOUT_CYC - 1);
   assign len_full = {rx_data, len_q[7:0]};

   assign write_addr = write_addr_q;
   assign write_data = write_data_q;
   assign w_en       = w_en_q;
   assign cpu_hold   = cpu_hold_q;
   assign load_done  = load_done_q;
   assign load_err   = load_err_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; a timeout in any in-frame state aborts to ERR.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (sync_hit) state_d = S_LEN0;
         S_LEN0: begin
            if (tmo_hit)       state_d = S_ERR;
            else if (rx_valid) state_d = S_LEN1;
         end
         S_LEN1: begin
            if (tmo_hit) state_d = S_ERR;
            else if (rx_valid) begin
               if (len_full == 16'd0)              state_d = S_CHK;
               else if ({17'd0, len_full} > DEPTH) state_d = S_ERR;
               else                                state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tmo_hit) state_d = S_ERR;
            else if (rx_valid && (byte_cnt_q == 2'd3) && (word_cnt_q + 16'd1 == len_q))
               state_d = S_CHK;
         end
         S_CHK: begin
            if (tmo_hit)       state_d = S_ERR;
            else if (rx_valid) state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and registered-output next values.
   // The write strobe for the last word lands in the first CHK cycle, so the
   // checksum byte may follow the final data byte without a gap.
   always_comb begin
      len_d        = len_q;
      word_cnt_d   = word_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      asm_d        = asm_q;
      chk_d        = chk_q;
      tmo_d        = rx_valid ? '0 : tmo_q + 32'd1;
      write_addr_d = w_en_q ? write_addr_q + ADDR_W'(4) : write_addr_q;
      write_data_d = write_data_q;
      w_en_d       = 1'b0;
      cpu_hold_d   = cpu_hold_q;
      load_done_d  = load_done_q;
      load_err_d   = load_err_q;
      case (state_q)
         S_IDLE: begin
            tmo_d = '0;
            if (sync_hit) begin
               load_done_d  = 1'b0;
               load_err_d   = 1'b0;
               write_addr_d = BASE;
               chk_d        = '0;
               byte_cnt_d   = '0;
               word_cnt_d   = '0;
               cpu_hold_d   = 1'b1;
            end
         end
         S_LEN0: if (rx_valid) begin
            len_d[7:0] = rx_data;
            chk_d      = chk_q ^ rx_data;
         end
         S_LEN1: if (rx_valid) begin
            len_d[15:8] = rx_data;
            chk_d       = chk_q ^ rx_data;
         end
         S_DATA: if (rx_valid) begin
            chk_d = chk_q ^ rx_data;
            case (byte_cnt_q)
               2'd0: asm_d[7:0]   = rx_data;
               2'd1: asm_d[15:8]  = rx_data;
               2'd2: asm_d[23:16] = rx_data;
               default: begin
                  write_data_d = {rx_data, asm_q};
                  w_en_d       = 1'b1;
                  word_cnt_d   = word_cnt_q + 16'd1;
               end
            endcase
            byte_cnt_d = byte_cnt_q + 2'd1;
         end
         S_DONE: begin
            tmo_d       = '0;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
         end
         S_ERR: begin
            tmo_d      = '0;
            load_err_d = 1'b1;
            cpu_hold_d = 1'b0;
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q        <= '0;
         word_cnt_q   <= '0;
         byte_cnt_q   <= '0;
         asm_q        <= '0;
         chk_q        <= '0;
         tmo_q        <= '0;
         write_addr_q <= BASE;
         write_data_q <= '0;
         w_en_q       <= 1'b0;
         cpu_hold_q   <= 1'b0;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         asm_q        <= asm_d;
         chk_q        <= chk_d;
         tmo_q        <= tmo_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         w_en_q       <= w_en_d;
         cpu_hold_q   <= cpu_hold_d;
         load_done_q  <= load_done_d;
         load_err_q   <= load_err_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built from the protocol
// rules, expected writes/outcomes derived from the frame contents.
module tb_imem_loader;

   localparam int unsigned AW  = 14;
   localparam int unsigned TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [AW-1:0] write_addr;
   logic [31:0]   write_data;
   logic          w_en;
   logic          cpu_hold;
   logic          load_done;
   logic          load_err;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [AW-1:0] wa_q[$];
   logic [31:0]   wd_q[$];
   int unsigned   wc_q[$];
   int unsigned   cyc = 0;

   always #5 clk = ~clk;

   imem_loader #(
      .ADDR_W(AW), .BASE_ADDR(0), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .write_addr(write_addr), .write_data(write_data), .w_en(w_en),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
   );

   always @(posedge clk) cyc++;

   // Write-port monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (w_en === 1'b1) begin
         wa_q.push_back(write_addr);
         wd_q.push_back(write_data);
         wc_q.push_back(cyc);
      end
   end

   // Builds a frame: sync, LEN little-endian, words little-endian, checksum.
   function automatic void build_frame(input logic [31:0] words[$], input int unsigned len,
                                       input logic [7:0] chk_flip, output logic [7:0] b[$]);
      logic [7:0] chk;
      logic [7:0] lo;
      logic [7:0] hi;
      lo = len[7:0];
      hi = len[15:8];
      b.delete();
      b.push_back(8'hA5);
      b.push_back(lo);
      b.push_back(hi);
      chk = lo ^ hi;
      foreach (words[i]) begin
         for (int unsigned k = 0; k < 4; k++) begin
            b.push_back(words[i][8*k +: 8]);
            chk = chk ^ words[i][8*k +: 8];
         end
      end
      b.push_back(chk ^ chk_flip);
   endfunction

   // Drives bytes starting at a falling edge; returns how many post-byte
   // samples saw cpu_hold low. Ends at the falling edge after the last byte.
   task automatic send_frame(input logic [7:0] b[$], input int unsigned max_gap,
                             output int unsigned hold_low);
      hold_low = 0;
      foreach (b[i]) begin
         rx_valid = 1'b1;
         rx_data  = b[i];
         @(negedge clk);
         rx_valid = 1'b0;
         if (cpu_hold !== 1'b1) hold_low++;
         if (i != b.size() - 1) repeat ($urandom_range(max_gap)) @(negedge clk);
      end
   endtask

   task automatic clear_mon;
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
   endtask

   task automatic test_reset;
      rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
      repeat (3) @(negedge clk);
      total_cnt++; if ({w_en, cpu_hold, load_done, load_err} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {w_en, cpu_hold, load_done, load_err}); else pass_cnt++;
      total_cnt++; if (write_addr !== '0 || write_data !== '0) $display("FAIL reset_bus got %h/%h want 0/0", write_addr, write_data); else pass_cnt++;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++; if ({w_en, cpu_hold, load_done, load_err} !== 4'b0) $display("FAIL reset_idle got %b want 0000", {w_en, cpu_hold, load_done, load_err}); else pass_cnt++;
   endtask

   task automatic test_nominal(input logic [7:0] last, input bit good);
      logic [7:0]  b[$];
      int unsigned hl;
      b = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};
      b[b.size()-1] = last;
      clear_mon();
      @(negedge clk);
      total_cnt++; if (cpu_hold !== 1'b0) $display("FAIL nom_hold_pre got %b want 0", cpu_hold); else pass_cnt++;
      send_frame(b, 0, hl);
      total_cnt++; if (hl != 0) $display("FAIL nom_hold_during got %0d low samples want 0", hl); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if ({load_done, load_err, cpu_hold} !== {good, !good, 1'b0}) $display("FAIL nom_result got done/err/hold %b want %b", {load_done, load_err, cpu_hold}, {good, !good, 1'b0}); else pass_cnt++;
      total_cnt++; if (wa_q.size() != 2) $display("FAIL nom_nwrites got %0d want 2", wa_q.size()); else pass_cnt++;
      if (wa_q.size() == 2) begin
         total_cnt++; if (wa_q[0] !== 14'h0000 || wd_q[0] !== 32'h00000013) $display("FAIL nom_w0 got %h:%h want 0000:00000013", wa_q[0], wd_q[0]); else pass_cnt++;
         total_cnt++; if (wa_q[1] !== 14'h0004 || wd_q[1] !== 32'hDEADBEEF) $display("FAIL nom_w1 got %h:%h want 0004:deadbeef", wa_q[1], wd_q[1]); else pass_cnt++;
      end
   endtask

   task automatic test_len_edges;
      logic [7:0]  b[$];
      int unsigned hl;
      clear_mon();
      @(negedge clk);
      b = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_frame(b, 2, hl);
      @(negedge clk);
      total_cnt++; if ({load_done, load_err, cpu_hold} !== 3'b100) $display("FAIL len0_result got %b want 100", {load_done, load_err, cpu_hold}); else pass_cnt++;
      total_cnt++; if (wa_q.size() != 0) $display("FAIL len0_nwrites got %0d want 0", wa_q.size()); else pass_cnt++;
      b = '{8'hA5, 8'h01, 8'h10};
      send_frame(b, 2, hl);
      @(negedge clk);
      total_cnt++; if ({load_done, load_err, cpu_hold} !== 3'b010) $display("FAIL lenbig_result got %b want 010", {load_done, load_err, cpu_hold}); else pass_cnt++;
      total_cnt++; if (wa_q.size() != 0) $display("FAIL lenbig_nwrites got %0d want 0", wa_q.size()); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      logic [31:0] words[$];
      logic [7:0]  b[$];
      int unsigned hl;
      clear_mon();
      for (int unsigned i = 0; i < 3; i++) words.push_back($urandom);
      build_frame(words, 3, 8'h00, b);
      @(negedge clk);
      send_frame(b, 0, hl);
      @(negedge clk);
      total_cnt++; if ({load_done, load_err} !== 2'b10) $display("FAIL b2b_result got %b want 10", {load_done, load_err}); else pass_cnt++;
      total_cnt++; if (wa_q.size() != 3) $display("FAIL b2b_nwrites got %0d want 3", wa_q.size()); else pass_cnt++;
      for (int unsigned i = 0; i < 3 && i < wa_q.size(); i++) begin
         total_cnt++; if (wa_q[i] !== AW'(4 * i) || wd_q[i] !== words[i]) $display("FAIL b2b_w%0d got %h:%h want %h:%h", i, wa_q[i], wd_q[i], AW'(4 * i), words[i]); else pass_cnt++;
         if (i > 0) begin
            total_cnt++; if (wc_q[i] - wc_q[i-1] != 4) $display("FAIL b2b_spacing%0d got %0d want 4", i, wc_q[i] - wc_q[i-1]); else pass_cnt++;
         end
      end
   endtask

   task automatic test_random_frames;
      for (int unsigned f = 0; f < 8; f++) begin
         logic [31:0] words[$];
         logic [7:0]  b[$];
         logic [7:0]  flip;
         int unsigned len;
         int unsigned hl;
         bit          good;
         len  = $urandom_range(6, 1);
         flip = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         good = (flip == 8'h00);
         for (int unsigned i = 0; i < len; i++) words.push_back($urandom);
         build_frame(words, len, flip, b);
         clear_mon();
         @(negedge clk);
         send_frame(b, 3, hl);
         @(negedge clk);
         total_cnt++; if ({load_done, load_err, cpu_hold} !== {good, !good, 1'b0} || hl != 0) $display("FAIL rnd%0d_result got %b hl=%0d want %b hl=0", f, {load_done, load_err, cpu_hold}, hl, {good, !good, 1'b0}); else pass_cnt++;
         total_cnt++; if (wa_q.size() != len) $display("FAIL rnd%0d_nwrites got %0d want %0d", f, wa_q.size(), len); else pass_cnt++;
         for (int unsigned i = 0; i < len && i < wa_q.size(); i++) begin
            total_cnt++; if (wa_q[i] !== AW'(4 * i) || wd_q[i] !== words[i]) $display("FAIL rnd%0d_w%0d got %h:%h want %h:%h", f, i, wa_q[i], wd_q[i], AW'(4 * i), words[i]); else pass_cnt++;
         end
      end
   endtask

   task automatic test_timeout;
      logic [7:0]  b[$];
      int unsigned hl;
      int unsigned k;
      clear_mon();
      b = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22};
      @(negedge clk);
      send_frame(b, 0, hl);
      k = 0;
      while (load_err !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      total_cnt++; if (load_err !== 1'b1) $display("FAIL tmo_err got %b want 1 within 40 cycles", load_err); else pass_cnt++;
      total_cnt++; if (k < 10) $display("FAIL tmo_early got %0d idle cycles want >= 10", k); else pass_cnt++;
      total_cnt++; if ({cpu_hold, load_done} !== 2'b00 || wa_q.size() != 0) $display("FAIL tmo_state got hold/done %b writes %0d want 00/0", {cpu_hold, load_done}, wa_q.size()); else pass_cnt++;
   endtask

   task automatic test_garbage;
      logic [7:0]  b[$];
      int unsigned hl;
      clear_mon();
      b = '{8'h11};
      @(negedge clk);
      send_frame(b, 0, hl);
      repeat (2) @(negedge clk);
      total_cnt++; if ({load_done, load_err, cpu_hold} !== 3'b010 || wa_q.size() != 0) $display("FAIL garbage got %b writes %0d want 010/0", {load_done, load_err, cpu_hold}, wa_q.size()); else pass_cnt++;
   endtask

   task automatic test_reset_mid_data;
      logic [31:0] words[$];
      logic [7:0]  b[$];
      int unsigned hl;
      clear_mon();
      b = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
      @(negedge clk);
      send_frame(b, 0, hl);
      #2 rst = 1'b1;
      #1;
      total_cnt++; if ({w_en, cpu_hold, load_done, load_err} !== 4'b0 || write_addr !== '0) $display("FAIL rstmid_async got %b addr %h want 0000 addr 0", {w_en, cpu_hold, load_done, load_err}, write_addr); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      words.push_back(32'h12345678);
      build_frame(words, 1, 8'h00, b);
      @(negedge clk);
      send_frame(b, 1, hl);
      @(negedge clk);
      total_cnt++; if ({load_done, load_err} !== 2'b10 || wa_q.size() != 1) $display("FAIL rstmid_reload got %b writes %0d want 10/1", {load_done, load_err}, wa_q.size()); else pass_cnt++;
      if (wa_q.size() == 1) begin
         total_cnt++; if (wa_q[0] !== '0 || wd_q[0] !== 32'h12345678) $display("FAIL rstmid_w0 got %h:%h want 0000:12345678", wa_q[0], wd_q[0]); else pass_cnt++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_nominal(8'h33, 1'b1);
      test_nominal(8'h34, 1'b0);
      test_len_edges();
      test_back_to_back();
      test_random_frames();
      test_timeout();
      test_garbage();
      test_reset_mid_data();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Bootloader front end that drives the programming (write) port of the instruction memory wrapper.
- Consumes a byte stream from a UART receiver and parses a framed program image: sync, length, data words, checksum.
- Emits word writes on write_addr/write_data/w_en.
- Holds the core via cpu_hold while a load is in progress.

Parameters:
- ADDR_W, 14, width of write_addr; byte address, word-aligned.
- BASE_ADDR, 0, byte address of the first word written; must be a multiple of 4.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 1000000, max idle cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- write_addr  output  ADDR_W  byte address to the imem programming port
- write_data  output  32  word to write
- w_en  output  1  one-cycle write strobe
- cpu_hold  output  1  high while a frame is being loaded; drives the core stall
- load_done  output  1  sticky: last frame completed with a good checksum
- load_err  output  1  sticky: last frame aborted

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; write_addr=BASE_ADDR; byte counter, checksum and timeout counter cleared. Memory contents written before reset stay in memory.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then LEN words of 4 bytes each, little-endian (first byte = bits 7:0), then CHK.
- CHK is the XOR of LEN_LO, LEN_HI and every data byte. SYNC_BYTE is not included.
- Capacity DEPTH = 2^(ADDR_W-2) - BASE_ADDR/4 words.
- States:
  - IDLE: rx_valid with rx_data==SYNC_BYTE moves to LEN0. Same cycle: clear load_done and load_err, write_addr<=BASE_ADDR, checksum<=0. Next cycle cpu_hold=1. Any other byte is ignored.
  - LEN0: capture LEN_LO -> LEN1.
  - LEN1: capture LEN_HI.
    - LEN==0 -> CHK.
    - LEN>DEPTH -> ERR.
    - Otherwise -> DATA.
  - DATA: shift bytes into a 32-bit assembly register and count 0..3.
    - On the 4th byte, in the next cycle: w_en=1 for exactly one cycle, write_data=assembled word, write_addr=current address. After that strobe, write_addr+=4.
    - When the word count reaches LEN -> CHK.
    - A byte arriving in the w_en cycle is accepted normally, so back-to-back bytes need no gaps.
  - CHK: received byte==running checksum -> DONE, else -> ERR.
  - DONE: load_done<=1; cpu_hold<=0; -> IDLE next cycle.
  - ERR: load_err<=1; cpu_hold<=0; -> IDLE next cycle.
- rx_valid during the DONE or ERR cycle is ignored.
- w_en is never asserted outside DATA.
- write_addr and write_data hold their last values when w_en=0.
- Timeout: the counter is cleared on every rx_valid and in IDLE. In LEN0/LEN1/DATA/CHK, reaching TIMEOUT_CYC-1 without rx_valid -> ERR. Words already written stay written.
- A SYNC_BYTE value inside a frame is treated as data; no resync mid-frame.
- cpu_hold is registered and glitch-free:
  - Asserts the cycle after sync is accepted.
  - Deasserts the cycle after DONE/ERR.
  - Drops immediately on rst.
- load_done and load_err are never both 1.

Test Plan:
- Reset mid-DATA (after 2 bytes of word 0) -> all outputs 0 immediately, state IDLE; a following full frame loads correctly from BASE_ADDR.
- Nominal frame A5,02,00,13,00,00,00,EF,BE,AD,DE,33 -> two w_en pulses:
  - addr 0x0000 data 0x00000013
  - addr 0x0004 data 0xDEADBEEF
  - then load_done=1, cpu_hold high from the cycle after A5 until the cycle after CHK.
- Same frame with CHK=34 -> both writes still occur, load_err=1, load_done=0.
- LEN=0 (A5,00,00,00) -> no w_en, load_done=1. Then a frame with LEN=0x1001 at ADDR_W=14 -> load_err right after LEN_HI, no w_en.
- Back-to-back rx_valid every cycle for 3 words -> 3 w_en pulses spaced 4 cycles apart, addresses 0,4,8, no byte lost.
- TIMEOUT_CYC=16, stream stops after 2 data bytes -> load_err=1 and cpu_hold=0 on timeout. Garbage byte 0x11 in IDLE -> no state change.
